camera_config_sequencer: RTL

Upstream command source for the camera's I2C/SCCB byte-write controller. Steps the camera through power-up and hardware reset, then walks an internal register table. Each table entry becomes one three-byte register write, handed to the controller through a valid/ready handshake. Failed writes are retried, and `config_done_o` tells the capture pipeline that the sensor is configured.

---
 rtl/camera_config_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/camera_config_sequencer.sv
// camera_config_sequencer: powers up the sensor, pulses its reset pin, then
// replays an internal register table as SCCB writes with NACK retries.
// Ports: clk_i/reset_ni, start_i; cmd_* valid/ready command to the SCCB
// controller; done_valid_i/ack_err_i completion; reset_cmos_o/pwdn_o pins;
// busy_o, config_done_o, error_o, index_o status.
module camera_config_sequencer #(
  parameter logic [7:0]  DEVICE_ADDR         = 8'h42,
  parameter int unsigned RESET_HOLD_CYCLES   = 1_000_000,
  parameter int unsigned POWERUP_WAIT_CYCLES = 2_000_000,
  parameter int unsigned SETTLE_CYCLES       = 1_000_000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter bit          AUTO_START          = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [7:0] cmd_dev_addr_o,
  output logic [7:0] cmd_reg_addr_o,
  output logic [7:0] cmd_data_o,
  input  logic       done_valid_i,
  input  logic       ack_err_i,
  output logic       reset_cmos_o,
  output logic       pwdn_o,
  output logic       busy_o,
  output logic       config_done_o,
  output logic       error_o,
  output logic [5:0] index_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_PWUP, S_FETCH, S_ISSUE,
    S_WAIT, S_DELAY, S_DONE, S_ERR
  } state_e;

  localparam logic [23:0] HOLD_LD   = 24'(RESET_HOLD_CYCLES - 1);
  localparam logic [23:0] PWUP_LD   = 24'(POWERUP_WAIT_CYCLES - 1);
  localparam logic [23:0] SETTLE_LD = 24'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

  localparam logic [15:0] E_END   = 16'hFFFF;
  localparam logic [15:0] E_DELAY = 16'hFFF0;

  function automatic logic [15:0] rom(input logic [5:0] a);
    logic [15:0] r;
    case (a)
      6'd0:    r = 16'h1280;
      6'd1:    r = E_DELAY;
      6'd2:    r = 16'h1204;
      6'd3:    r = 16'h40D0;
      6'd4:    r = 16'h1101;
      default: r = E_END;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] entry_q;
  logic        first_q;
  logic        valid_q, rcmos_q, pwdn_q;
  logic        busy_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    reg_d   = reg_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i || (AUTO_START && first_q)) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt_q == 24'd0) begin
          state_d = S_PWUP;
          cnt_d   = PWUP_LD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_PWUP: begin
        if (cnt_q == 24'd0) begin
          state_d = S_FETCH;
          idx_d   = 6'd0;
          retry_d = 8'd0;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_FETCH: begin
        // Index 63 terminates the table so the index never wraps.
        if (entry_q == E_END || idx_q == 6'd63) begin
          state_d = S_DONE;
        end else if (entry_q == E_DELAY) begin
          state_d = S_DELAY;
          cnt_d   = SETTLE_LD;
        end else begin
          state_d = S_ISSUE;
          reg_d   = entry_q[15:8];
          data_d  = entry_q[7:0];
        end
      end
      S_ISSUE: begin
        if (cmd_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_valid_i) begin
          if (!ack_err_i) begin
            state_d = S_FETCH;
            idx_d   = idx_q + 6'd1;
            retry_d = 8'd0;
          end else if (retry_q < RETRY_MAX) begin
            state_d = S_ISSUE;
            retry_d = retry_q + 8'd1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == 24'd0) begin
          state_d = S_FETCH;
          idx_d   = idx_q + 6'd1;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they switch on the
  // same edge as the state itself.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 24'd0;
      idx_q   <= 6'd0;
      retry_q <= 8'd0;
      reg_q   <= 8'd0;
      data_q  <= 8'd0;
      entry_q <= 16'd0;
      first_q <= 1'b1;
      valid_q <= 1'b0;
      rcmos_q <= 1'b0;
      pwdn_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      entry_q <= rom(idx_d);
      first_q <= 1'b0;
      valid_q <= (state_d == S_ISSUE);
      rcmos_q <= !(state_d == S_IDLE || state_d == S_HOLD);
      pwdn_q  <= (state_d == S_IDLE);
      busy_q  <= !(state_d == S_IDLE || state_d == S_DONE ||
                   state_d == S_ERR);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign cmd_valid_o    = valid_q;
  assign cmd_dev_addr_o = DEVICE_ADDR;
  assign cmd_reg_addr_o = reg_q;
  assign cmd_data_o     = data_q;
  assign reset_cmos_o   = rcmos_q;
  assign pwdn_o         = pwdn_q;
  assign busy_o         = busy_q;
  assign config_done_o  = done_q;
  assign error_o        = err_q;
  assign index_o        = idx_q;

endmodule
